position_i2c_responder: RTL and testbench

I2C target (responder) that answers the position peripheral's I2C master on the same SCL/SDA pair, exposing an 8 × 8-bit register bank. The local side loads sensor words into the bank, and the master reads them back over I2C. Master writes are applied to the bank and reported to the local side as a one-cycle strobe. It sits on the sensor side of the bus, as a synthesizable stand-in for the position sensor and as the bus partner in position-peripheral benches.

---
 rtl/position_i2c_responder.sv | 157 +++++++++++++++
 tb/tb_position_i2c_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_i2c_responder.sv
// position_i2c_responder: I2C target exposing an 8x8 register bank; define POSITION_RESP_AUTOINC_EN for pointer auto-increment.
module position_i2c_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h29,
    parameter logic [7:0] RESET_FILL  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_oen,
    output logic       SDA_out,
    input  logic       ld_en,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_t;
    state_t state, state_n;
    logic [1:0] scl_s, sda_s;
    logic scl_d, sda_d, scl, sda, scl_rise, scl_fall, start_c, stop_c;
    logic [2:0] bitcnt, bit_n, ptr, ptr_n, ptr_inc;
    logic [7:0] sr, sr_n, byte_in;
    logic [7:0] bank [8];
    logic ack_on, ack_n, rw, rw_n, oen_n, busy_n, mwr;
    assign scl = scl_s[1];
    assign sda = sda_s[1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start_c = scl & scl_d & sda_d & ~sda;
    assign stop_c = scl & scl_d & ~sda_d & sda;
    assign byte_in = {sr[6:0], sda};
    assign SDA_out = 1'b0;
`ifdef POSITION_RESP_AUTOINC_EN
    assign ptr_inc = ptr + 3'd1;
`else
    assign ptr_inc = ptr;
`endif
    always_comb begin
        state_n = state;
        bit_n = bitcnt;
        sr_n = sr;
        oen_n = SDA_oen;
        ack_n = ack_on;
        ptr_n = ptr;
        busy_n = busy;
        rw_n = rw;
        mwr = 1'b0;
        if (stop_c) begin
            state_n = IDLE;
            busy_n = 1'b0;
            oen_n = 1'b0;
            ack_n = 1'b0;
        end else if (start_c) begin
            state_n = ADDR;
            bit_n = 3'd0;
            oen_n = 1'b0;
            ack_n = 1'b0;
        end else if (scl_rise) begin
            if (state == ADDR || state == PTR || state == WDATA) begin
                sr_n = byte_in;
                bit_n = bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    if (state == ADDR) begin
                        state_n = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IDLE;
                        busy_n = (byte_in[7:1] == TARGET_ADDR) ? 1'b1 : busy;
                        rw_n = byte_in[0];
                    end else if (state == PTR) begin
                        ptr_n = byte_in[2:0];
                        state_n = PTR_ACK;
                    end else begin
                        mwr = 1'b1;
                        state_n = WDATA_ACK;
                    end
                end
            end else if (state == RDATA_ACK) begin
                state_n = sda ? IDLE : RDATA_ACK;
                ptr_n = sda ? ptr : ptr_inc;
            end
        end else if (scl_fall) begin
            if (state == ADDR_ACK || state == PTR_ACK || state == WDATA_ACK) begin
                // first fall after bit 8 asserts ACK, the next one ends the ACK slot
                if (!ack_on) begin
                    oen_n = 1'b1;
                    ack_n = 1'b1;
                end else begin
                    oen_n = 1'b0;
                    ack_n = 1'b0;
                    bit_n = 3'd0;
                    state_n = (state == ADDR_ACK) ? (rw ? RDATA : PTR) : WDATA;
                    ptr_n = (state == WDATA_ACK) ? ptr_inc : ptr;
                    if (state == ADDR_ACK && rw) begin
                        sr_n = bank[ptr];
                        oen_n = ~bank[ptr][7];
                    end
                end
            end else if (state == RDATA) begin
                if (bitcnt == 3'd7) begin
                    oen_n = 1'b0;
                    state_n = RDATA_ACK;
                end else begin
                    bit_n = bitcnt + 3'd1;
                    sr_n = {sr[6:0], 1'b0};
                    oen_n = ~sr[6];
                end
            end else if (state == RDATA_ACK) begin
                sr_n = bank[ptr];
                oen_n = ~bank[ptr][7];
                bit_n = 3'd0;
                state_n = RDATA;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            state <= IDLE;
            bitcnt <= 3'd0;
            sr <= 8'd0;
            ack_on <= 1'b0;
            rw <= 1'b0;
            ptr <= 3'd0;
            SDA_oen <= 1'b0;
            busy <= 1'b0;
            wr_stb <= 1'b0;
            wr_addr <= 3'd0;
            wr_data <= 8'd0;
            for (int i = 0; i < 8; i++) bank[i] <= RESET_FILL;
        end else begin
            scl_s <= {scl_s[0], SCL};
            sda_s <= {sda_s[0], SDA_in};
            scl_d <= scl;
            sda_d <= sda;
            state <= state_n;
            bitcnt <= bit_n;
            sr <= sr_n;
            ack_on <= ack_n;
            rw <= rw_n;
            ptr <= ptr_n;
            SDA_oen <= oen_n;
            busy <= busy_n;
            wr_stb <= mwr;
            if (mwr) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
                bank[ptr] <= byte_in;
            end
            // local load is applied last so it wins a same-index collision
            if (ld_en) bank[ld_addr] <= ld_data;
        end
    end
endmodule

// File: tb/tb_position_i2c_responder.sv
// tb_position_i2c_responder: bit-banged I2C master with a transaction-level register-bank model.
module tb_position_i2c_responder;
    logic clk = 0, rst = 0, SCL = 1, m_sda = 1, ld_en = 0;
    logic [2:0] ld_addr = 0;
    logic [7:0] ld_data = 0;
    logic SDA_in, SDA_oen, SDA_out, wr_stb, busy;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    int total = 0, bad = 0, oen_cnt = 0;
    logic [7:0] bank_m [8];
    logic [2:0] ptr_m;
    logic [10:0] exp_q[$], stb_q[$];
    logic [7:0] wbuf [8], rbuf [8], ebuf [8];
    bit stb_wide, stb_prev, poke_en, busy_mid;
    logic [2:0] poke_a;
    logic [7:0] poke_d;
`ifdef POSITION_RESP_AUTOINC_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    position_i2c_responder #(.TARGET_ADDR(7'h29), .RESET_FILL(8'h00)) dut (
        .clk(clk), .rst(rst), .SCL(SCL), .SDA_in(SDA_in), .SDA_oen(SDA_oen), .SDA_out(SDA_out),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy));

    assign SDA_in = m_sda & ~SDA_oen;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) stb_q.push_back({wr_addr, wr_data});
        if (wr_stb && stb_prev) stb_wide = 1;
        stb_prev = wr_stb;
        if (SDA_oen) oen_cnt++;
    end

    task automatic dly(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) bank_m[i] = 8'h00;
        ptr_m = 0;
    endtask

    task automatic ld(input logic [2:0] a, input logic [7:0] d);
        ld_addr = a; ld_data = d; ld_en = 1;
        @(posedge clk); #2 ld_en = 0;
        bank_m[a] = d;
    endtask

    task automatic i2c_start();
        m_sda = 1; dly(5); SCL = 1; dly(10); m_sda = 0; dly(10); SCL = 0; dly(5);
    endtask

    task automatic i2c_stop();
        m_sda = 0; dly(5); SCL = 1; dly(10); m_sda = 1; dly(10);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; dly(5); SCL = 1; dly(10); SCL = 0; dly(5);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1; dly(5); SCL = 1; dly(5); b = SDA_in; dly(5); SCL = 0; dly(5);
    endtask

    // collide: pulse ld_en for exactly the cycle in which the DUT commits the 8th bit
    task automatic write_byte(input logic [7:0] b, output logic ack, input bit collide);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; dly(5); SCL = 1;
            if (collide && i == 0) begin
                repeat (2) @(posedge clk);
                #2 ld_en = 1;
                @(posedge clk); #2 ld_en = 0;
                dly(7);
            end else dly(10);
            SCL = 0; dly(5);
        end
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(t);
            d[i] = t;
            if (i == 4 && poke_en) begin
                ld(poke_a, poke_d);
                poke_en = 0;
            end
        end
        send_bit(nack);
    endtask

    task automatic m_write(input logic [2:0] p, input int n, input bit do_stop, output int nk);
        logic a;
        nk = 0;
        i2c_start();
        write_byte({7'h29, 1'b0}, a, 0); nk += int'(a);
        write_byte({5'($urandom), p}, a, 0); nk += int'(a);
        ptr_m = p;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a, 0); nk += int'(a);
            bank_m[ptr_m] = wbuf[i];
            exp_q.push_back({ptr_m, wbuf[i]});
            ptr_m = 3'(ptr_m + STEP);
        end
        if (do_stop) i2c_stop();
    endtask

    task automatic m_read(input int n, output int nk);
        logic a;
        logic [7:0] d;
        nk = 0;
        i2c_start();
        write_byte({7'h29, 1'b1}, a, 0); nk += int'(a);
        busy_mid = busy;
        for (int i = 0; i < n; i++) begin
            ebuf[i] = bank_m[ptr_m];
            read_byte(i == n - 1, d);
            rbuf[i] = d;
            if (i < n - 1) ptr_m = 3'(ptr_m + STEP);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        int nk;
        rst = 0; repeat (3) @(posedge clk); #2;
        total++; if (SDA_oen !== 0) begin bad++; $display("FAIL rst_oen got=%b want=0", SDA_oen); end
        total++; if (SDA_out !== 0) begin bad++; $display("FAIL rst_out got=%b want=0", SDA_out); end
        total++; if (wr_stb !== 0) begin bad++; $display("FAIL rst_stb got=%b want=0", wr_stb); end
        total++; if (wr_addr !== 0 || wr_data !== 0) begin bad++; $display("FAIL rst_wr got=%h/%h want=0/00", wr_addr, wr_data); end
        total++; if (busy !== 0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        rst = 1; dly(5);
        model_reset();
        m_read(1, nk);
        total++; if (nk != 0) begin bad++; $display("FAIL rst_read_ack got=%0d nacks want=0", nk); end
        total++; if (busy_mid !== 1) begin bad++; $display("FAIL rst_busy_mid got=%b want=1", busy_mid); end
        total++; if (rbuf[0] !== ebuf[0]) begin bad++; $display("FAIL rst_read got=%h want=%h", rbuf[0], ebuf[0]); end
        total++; if (SDA_oen !== 0 || busy !== 0) begin bad++; $display("FAIL rst_after_stop got=%b%b want=00", SDA_oen, busy); end
    endtask

    task automatic test_load_read();
        int nk, nk2;
        ld(3'd2, 8'hA5); ld(3'd3, 8'h3C);
        m_write(3'd2, 0, 0, nk);
        m_read(2, nk2);
        total++; if (nk + nk2 != 0) begin bad++; $display("FAIL ldrd_ack got=%0d nacks want=0", nk + nk2); end
        for (int i = 0; i < 2; i++) begin
            total++; if (rbuf[i] !== ebuf[i]) begin bad++; $display("FAIL ldrd_byte%0d got=%h want=%h", i, rbuf[i], ebuf[i]); end
        end
    endtask

    task automatic test_burst_write();
        int nk, nk2;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        exp_q.delete(); stb_q.delete(); stb_wide = 0;
        m_write(3'd6, 3, 1, nk);
        dly(5);
        total++; if (nk != 0) begin bad++; $display("FAIL bw_ack got=%0d nacks want=0", nk); end
        total++; if (stb_q.size() != exp_q.size()) begin bad++; $display("FAIL bw_stb_count got=%0d want=%0d", stb_q.size(), exp_q.size()); end
        while (stb_q.size() > 0 && exp_q.size() > 0) begin
            logic [10:0] g, w;
            g = stb_q.pop_front(); w = exp_q.pop_front();
            total++; if (g !== w) begin bad++; $display("FAIL bw_stb got=%h want=%h", g, w); end
        end
        total++; if (stb_wide !== 0) begin bad++; $display("FAIL bw_stb_width got=wide want=1clk"); end
        m_write(3'd6, 0, 0, nk);
        m_read(3, nk2);
        total++; if (nk + nk2 != 0) begin bad++; $display("FAIL bw_rd_ack got=%0d nacks want=0", nk + nk2); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rbuf[i] !== ebuf[i]) begin bad++; $display("FAIL bw_rd%0d got=%h want=%h", i, rbuf[i], ebuf[i]); end
        end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        oen_cnt = 0; stb_q.delete();
        i2c_start();
        write_byte({7'h28, 1'b0}, a, 0);
        total++; if (a !== 1) begin bad++; $display("FAIL mis_ack got=%b want=1", a); end
        total++; if (busy !== 0) begin bad++; $display("FAIL mis_busy got=%b want=0", busy); end
        write_byte(8'h5A, a, 0);
        i2c_stop();
        total++; if (oen_cnt != 0) begin bad++; $display("FAIL mis_oen got=%0d want=0", oen_cnt); end
        total++; if (stb_q.size() != 0) begin bad++; $display("FAIL mis_stb got=%0d want=0", stb_q.size()); end
    endtask

    task automatic test_collision();
        logic a1, a2, a3;
        int nk, nk2;
        exp_q.delete(); stb_q.delete();
        ld_addr = 3'd4; ld_data = 8'h77;
        i2c_start();
        write_byte({7'h29, 1'b0}, a1, 0);
        write_byte(8'h04, a2, 0);
        write_byte(8'h99, a3, 1);
        i2c_stop();
        ptr_m = 3'd4; bank_m[4] = 8'h77; exp_q.push_back({3'd4, 8'h99}); ptr_m = 3'(ptr_m + STEP);
        total++; if ({a1, a2, a3} !== 3'b000) begin bad++; $display("FAIL col_ack got=%b want=000", {a1, a2, a3}); end
        total++; if (stb_q.size() != 1 || stb_q[0] !== exp_q[0]) begin bad++; $display("FAIL col_stb got=%0d entries want=1 of %h", stb_q.size(), exp_q[0]); end
        total++; if (wr_data !== 8'h99 || wr_addr !== 3'd4) begin bad++; $display("FAIL col_wr got=%h/%h want=4/99", wr_addr, wr_data); end
        m_write(3'd4, 0, 0, nk);
        m_read(1, nk2);
        total++; if (rbuf[0] !== ebuf[0]) begin bad++; $display("FAIL col_bank got=%h want=%h", rbuf[0], ebuf[0]); end
    endtask

    task automatic test_snapshot();
        int nk, nk2;
        ld(3'd5, 8'hC3);
        poke_en = 1; poke_a = 3'd5; poke_d = 8'h18;
        m_write(3'd5, 0, 0, nk);
        m_read(1, nk2);
        total++; if (rbuf[0] !== ebuf[0]) begin bad++; $display("FAIL snap_tx got=%h want=%h", rbuf[0], ebuf[0]); end
        m_write(3'd5, 0, 0, nk);
        m_read(1, nk2);
        total++; if (rbuf[0] !== ebuf[0]) begin bad++; $display("FAIL snap_after got=%h want=%h", rbuf[0], ebuf[0]); end
    endtask

    task automatic test_abort();
        logic a;
        int nk, nk2, waited;
        ld(3'd1, 8'h00);
        m_write(3'd1, 0, 0, nk);
        i2c_start();
        write_byte({7'h29, 1'b1}, a, 0);
        waited = 0;
        while (SDA_oen !== 1 && waited < 20) begin @(posedge clk); #2; waited++; end
        total++; if (SDA_oen !== 1) begin bad++; $display("FAIL abort_drive got=%b want=1", SDA_oen); end
        @(posedge clk); #2 rst = 0;
        @(posedge clk); #1;
        total++; if (SDA_oen !== 0 || busy !== 0) begin bad++; $display("FAIL abort_release got=%b%b want=00", SDA_oen, busy); end
        repeat (2) @(posedge clk);
        #2 rst = 1;
        model_reset();
        SCL = 1; dly(5); m_sda = 1; dly(10);
        for (int i = 0; i < 2; i++) wbuf[i] = 8'($urandom);
        exp_q.delete(); stb_q.delete();
        m_write(3'd3, 2, 1, nk);
        m_write(3'd3, 0, 0, nk2);
        total++; if (nk + nk2 != 0) begin bad++; $display("FAIL abort_next_ack got=%0d nacks want=0", nk + nk2); end
        m_read(2, nk);
        for (int i = 0; i < 2; i++) begin
            total++; if (rbuf[i] !== ebuf[i]) begin bad++; $display("FAIL abort_next%0d got=%h want=%h", i, rbuf[i], ebuf[i]); end
        end
    endtask

    task automatic test_random();
        int nk, nk2, n;
        logic [2:0] p;
        for (int it = 0; it < 10; it++) begin
            p = 3'($urandom);
            case ($urandom_range(0, 2))
                0: ld(p, 8'($urandom));
                1: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                    exp_q.delete(); stb_q.delete();
                    m_write(p, n, 1, nk);
                    dly(3);
                    total++; if (nk != 0 || stb_q.size() != n) begin bad++; $display("FAIL rnd_wr got=%0d nacks %0d stb want=0 %0d", nk, stb_q.size(), n); end
                    while (stb_q.size() > 0 && exp_q.size() > 0) begin
                        logic [10:0] g, w;
                        g = stb_q.pop_front(); w = exp_q.pop_front();
                        total++; if (g !== w) begin bad++; $display("FAIL rnd_stb got=%h want=%h", g, w); end
                    end
                end
                default: begin
                    n = $urandom_range(1, 3);
                    m_write(p, 0, 0, nk);
                    m_read(n, nk2);
                    total++; if (nk + nk2 != 0) begin bad++; $display("FAIL rnd_rd_ack got=%0d want=0", nk + nk2); end
                    for (int i = 0; i < n; i++) begin
                        total++; if (rbuf[i] !== ebuf[i]) begin bad++; $display("FAIL rnd_rd%0d got=%h want=%h", i, rbuf[i], ebuf[i]); end
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_burst_write();
        test_addr_mismatch();
        test_collision();
        test_snapshot();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
